eater_core: RTL and testbench
=============================

// Module: eater_core
// PURPOSE
//  Parametrised successor to the bus-based 8-bit core: one self-contained CPU with an internal
//  program counter, microstep sequencer, A/B registers, flags, unified RAM and an output register.
//  Width and depth are generic, and variable-length instructions end early (no dead microsteps).
//  A halted-state program-load port fills RAM from the test/host side.
// PARAMETERS
//  DATA_W  8  datapath/word width; opcode is the top 4 bits, operand is the low DATA_W-4 bits
//  ADDR_W  4  RAM address width, depth 2**ADDR_W; must satisfy ADDR_W <= DATA_W-4
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  run        in   1       while halted: start executing at the next edge
//  prog_we    in   1       RAM write strobe; honoured only while halted
//  prog_addr  in   ADDR_W  program-load address
//  prog_data  in   DATA_W  program-load data
//  out_val    out  DATA_W  OUT register
//  out_valid  out  1       one-cycle pulse when out_val is updated
//  halted     out  1       1 in HALT state
//  pc         out  ADDR_W  current program counter (debug)
// BEHAVIOUR
//  Reset: PC/A/B/IR/MAR/flags/out_val=0, out_valid=0, state HALT (halted=1). RAM contents are kept.
//  Reset mid-instruction: abandon the instruction. Reset wins over run and prog_we.
//  HALT: prog_we writes RAM[prog_addr]. If run=1, go to T0 next cycle; a write in the same cycle is seen by that fetch.
//  RUN: prog_we ignored; run ignored. Step counter T0..T4, one step per clock.
//  Fetch: T0 MAR<=PC; T1 IR<=RAM[MAR], PC<=PC+1 (wraps 2**ADDR_W-1 -> 0).
//  Execute (opr=IR operand; addr=opr[ADDR_W-1:0]); after an instruction's last step the next step is T0:
//   0 NOP: T2 none
//   1 LDA: T2 MAR<=addr; T3 A<=RAM[MAR]
//   2 ADD: T2 MAR<=addr; T3 B<=RAM[MAR]; T4 A<=A+B, set flags
//   3 SUB: as ADD, T4 A<=A+~B+1, set flags
//   4 STA: T2 MAR<=addr; T3 RAM[MAR]<=A
//   5 LDI: T2 A<=zero-extended opr
//   6 JMP: T2 PC<=addr
//   7 JC:  T2 PC<=addr if C
//   8 JZ:  T2 PC<=addr if Z
//   E OUT: T2 out_val<=A, out_valid=1 for that cycle only
//   F HLT: T2 -> HALT
//   9-D: execute as NOP
//  Arithmetic is modulo 2**DATA_W. C = carry out of the DATA_W+1-bit sum (SUB: C=1 iff A>=B unsigned).
//  Z = (result==0). Flags change only at ADD/SUB T4.
//  CPI: NOP/LDI/JMP/JC/JZ/OUT/HLT 3 clocks, LDA/STA 4, ADD/SUB 5.
//  RAM: combinational read by MAR, synchronous write. A jump taken to the address of the jump itself loops forever; that is legal.
// TESTING (DATA_W=8, ADDR_W=4 unless noted)
//  1 Load 1E 2F E0 F0, RAM[14]=28, RAM[15]=14; reset, pulse run -> out_valid exactly once with
//    out_val=42, 14 clocks from T0 of the first instruction to HALT entry; halted=1, pc=4.
//  2 Load E0 2F 74 60 F0, RAM[15]=1 -> 256 out_valid pulses carrying 0..255 in order, then halted;
//    A=0, C=1, Z=1.
//  3 LDI 5; SUB 15 with RAM[15]=7; JC 4 -> A=0xFE, C=0, Z=0, jump not taken (pc past JC).
//  4 STA/LDA round-trip with DATA_W=12, ADDR_W=5, value 0xABC at addr 31 -> out_val=0xABC;
//    PC wrap from 31 to 0 is checked.
//  5 prog_we during RUN -> RAM unchanged. Reset asserted at ADD T3 -> next cycle halted=1,
//    A/B/PC=0, RAM still holds the program, rerun gives the same result as test 1.
//  6 Undefined opcode 0xA0 followed by OUT -> behaves as NOP (3 clocks), A unchanged, out_val=A.

Source files
------------

// File: rtl/eater_core.sv
// -----------------------------------------------------------------------------
// eater_core
//   Small accumulator CPU: program counter, T0..T4 microstep sequencer,
//   A/B registers, carry/zero flags, one RAM shared by code and data, and an
//   output register. Instructions finish after their last useful step, so
//   NOP-class opcodes take 3 clocks, LDA/STA 4, and ADD/SUB 5.
//   Instruction word: opcode in the top 4 bits, operand in the rest; memory
//   operands use the low ADDR_W bits of the operand.
//
// Parameters
//   DATA_W  word width (opcode = top 4 bits)
//   ADDR_W  RAM address width, depth 2**ADDR_W (ADDR_W <= DATA_W-4)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset (RAM contents survive)
//   run        while halted, start fetching at the next edge
//   prog_we    RAM write strobe, honoured only while halted
//   prog_addr  program-load address
//   prog_data  program-load data
//   out_val    OUT register
//   out_valid  one-cycle pulse in the cycle out_val takes a new value
//   halted     1 while in the HALT state
//   pc         current program counter
// -----------------------------------------------------------------------------
module eater_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_val,
   output logic              out_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);

   // Sequencer states: T0..T4 are the microsteps, HALT is the idle/load state.
   localparam logic [2:0] S_T0   = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_T3   = 3'd3;
   localparam logic [2:0] S_T4   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              out_valid_q, out_valid_d;

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_data;

   logic [3:0]        opcode;
   logic [DATA_W-5:0] opr;
   logic [ADDR_W-1:0] opr_addr;
   logic              is_sub;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;

   assign opcode   = ir_q[DATA_W-1 -: 4];
   assign opr      = ir_q[DATA_W-5:0];
   assign opr_addr = opr[ADDR_W-1:0];
   assign rd_data  = mem[mar_q];

   // SUB is A + ~B + 1, so the carry out reads as "no borrow" (A >= B).
   assign is_sub = (opcode == OP_SUB);
   assign b_eff  = is_sub ? ~b_q : b_q;
   assign sum    = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      mar_d       = mar_q;
      ir_d        = ir_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      z_d         = z_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = prog_addr;
      mem_wdata   = prog_data;

      case (state_q)
         S_HALT: begin
            mem_we = prog_we;
            if (run) state_d = S_T0;
         end
         S_T0: begin
            mar_d   = pc_q;
            state_d = S_T1;
         end
         S_T1: begin
            ir_d    = rd_data;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_T2;
         end
         S_T2: begin
            state_d = S_T0;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  mar_d   = opr_addr;
                  state_d = S_T3;
               end
               OP_LDI: a_d = {4'b0000, opr};
               OP_JMP: pc_d = opr_addr;
               OP_JC:  if (c_q) pc_d = opr_addr;
               OP_JZ:  if (z_q) pc_d = opr_addr;
               OP_OUT: begin
                  out_d       = a_q;
                  out_valid_d = 1'b1;
               end
               OP_HLT: state_d = S_HALT;
               default: ;  // undefined opcodes retire as NOP
            endcase
         end
         S_T3: begin
            state_d = S_T0;
            case (opcode)
               OP_LDA: a_d = rd_data;
               OP_ADD, OP_SUB: begin
                  b_d     = rd_data;
                  state_d = S_T4;
               end
               OP_STA: begin
                  mem_we    = 1'b1;
                  mem_waddr = mar_q;
                  mem_wdata = a_q;
               end
               default: ;
            endcase
         end
         S_T4: begin
            a_d     = sum[DATA_W-1:0];
            c_d     = sum[DATA_W];
            z_d     = (sum[DATA_W-1:0] == '0);
            state_d = S_T0;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q     <= S_HALT;
         pc_q        <= '0;
         mar_q       <= '0;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         mar_q       <= mar_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         z_q         <= z_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // NOTE: the RAM has no reset so a loaded program survives reset and the
   // array maps onto plain memory; reset only blocks the write.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
   end

   assign out_val   = out_q;
   assign out_valid = out_valid_q;
   assign halted    = (state_q == S_HALT);
   assign pc        = pc_q;

endmodule

// File: tb/tb_eater_core.sv
// -----------------------------------------------------------------------------
// tb_eater_core
//   Directed programs on an 8-bit/16-word core and a 12-bit/32-word core.
//   Expected OUT values are queued before each program runs; a monitor per
//   core pops and compares on every out_valid pulse.
// -----------------------------------------------------------------------------
module tb_eater_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit / 16-word instance
   logic       rst8 = 1'b1, run8 = 1'b0, we8 = 1'b0;
   logic [3:0] addr8 = '0;
   logic [7:0] data8 = '0;
   logic [7:0] out_val8;
   logic       out_valid8, halted8;
   logic [3:0] pc8;

   // 12-bit / 32-word instance
   logic        rst12 = 1'b1, run12 = 1'b0, we12 = 1'b0;
   logic [4:0]  addr12 = '0;
   logic [11:0] data12 = '0;
   logic [11:0] out_val12;
   logic        out_valid12, halted12;
   logic [4:0]  pc12;

   eater_core #(.DATA_W(8), .ADDR_W(4)) dut8 (
      .clock(clk), .reset(rst8), .run(run8), .prog_we(we8),
      .prog_addr(addr8), .prog_data(data8), .out_val(out_val8),
      .out_valid(out_valid8), .halted(halted8), .pc(pc8));

   eater_core #(.DATA_W(12), .ADDR_W(5)) dut12 (
      .clock(clk), .reset(rst12), .run(run12), .prog_we(we12),
      .prog_addr(addr12), .prog_data(data12), .out_val(out_val12),
      .out_valid(out_valid12), .halted(halted12), .pc(pc12));

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  exp8  [$];
   logic [11:0] exp12 [$];
   logic [7:0]  img8  [16];
   logic [11:0] img12 [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitors, sampling on the falling edge.
   always @(negedge clk) begin
      if (out_valid8 === 1'b1) begin
         check("out8_expected", 32'(exp8.size() != 0), 1);
         if (exp8.size() != 0) check("out8_val", 32'(out_val8), 32'(exp8.pop_front()));
      end
      if (out_valid12 === 1'b1) begin
         check("out12_expected", 32'(exp12.size() != 0), 1);
         if (exp12.size() != 0) check("out12_val", 32'(out_val12), 32'(exp12.pop_front()));
      end
   end

   task automatic reset8();
      @(posedge clk); #1 rst8 = 1'b1;
      @(posedge clk); #1 rst8 = 1'b0;
   endtask

   task automatic load8();
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         we8 = 1'b1; addr8 = 4'(i); data8 = img8[i];
      end
      @(posedge clk); #1 we8 = 1'b0;
   endtask

   // Pulse run (optionally writing RAM[0]=0x59 in that same cycle) and
   // count the cycles spent out of HALT.
   task automatic go8(input bit wr0, input int budget, output int n);
      @(posedge clk); #1;
      run8 = 1'b1;
      if (wr0) begin we8 = 1'b1; addr8 = 4'd0; data8 = 8'h59; end
      @(posedge clk); #1;
      run8 = 1'b0; we8 = 1'b0;
      n = 0;
      while (!halted8 && n < budget) begin
         @(posedge clk); #1 n++;
      end
      check("halt8_reached", 32'(halted8), 1);
   endtask

   task automatic img_test1();
      img8 = '{default: 8'h00};
      img8[0] = 8'h1E; img8[1] = 8'h2F; img8[2] = 8'hE0; img8[3] = 8'hF0;
      img8[14] = 8'd28; img8[15] = 8'd14;
   endtask

   int n;
   bit found;

   initial begin
      // Reset state
      reset8();
      check("rst_halted", 32'(halted8), 1);
      check("rst_pc", 32'(pc8), 0);
      check("rst_out_val", 32'(out_val8), 0);
      check("rst_out_valid", 32'(out_valid8), 0);

      // Test 1: 28 + 14 = 42. halted is low for the 15 clocks of
      // LDA(4)+ADD(5)+OUT(3)+HLT(3); the HLT's last step is 14 clocks after T0.
      img_test1();
      load8();
      reset8();
      exp8.push_back(8'd42);
      go8(0, 100, n);
      check("t1_cycles", n, 15);
      check("t1_pc", 32'(pc8), 4);
      check("t1_outs_left", exp8.size(), 0);

      // Test 2: count 0..255 until carry, then halt.
      img8 = '{default: 8'h00};
      img8[0] = 8'hE0; img8[1] = 8'h2F; img8[2] = 8'h74; img8[3] = 8'h60;
      img8[4] = 8'hF0; img8[15] = 8'h01;
      load8();
      reset8();
      for (int i = 0; i < 256; i++) exp8.push_back(8'(i));
      go8(0, 5000, n);
      check("t2_outs_left", exp8.size(), 0);
      check("t2_a", 32'(dut8.a_q), 0);
      check("t2_c", 32'(dut8.c_q), 1);
      check("t2_z", 32'(dut8.z_q), 1);

      // Test 3: 5 - 7 = 0xFE, no carry so JC 4 falls through to OUT.
      img8 = '{default: 8'h00};
      img8[0] = 8'h55; img8[1] = 8'h3F; img8[2] = 8'h74; img8[3] = 8'hE0;
      img8[4] = 8'hF0; img8[15] = 8'h07;
      load8();
      reset8();
      exp8.push_back(8'hFE);
      go8(0, 100, n);
      check("t3_a", 32'(dut8.a_q), 32'hFE);
      check("t3_c", 32'(dut8.c_q), 0);
      check("t3_z", 32'(dut8.z_q), 0);
      check("t3_pc", 32'(pc8), 5);
      check("t3_outs_left", exp8.size(), 0);

      // Test 4 (12-bit core): 0xABC copied 30 -> 31, read back and output;
      // RAM[0] is then overwritten with HLT and JMP 31 executes 0xABC as a
      // NOP, so PC must wrap 31 -> 0 to reach the halt.
      img12 = '{default: 12'h000};
      img12[0] = 12'h11E; img12[1] = 12'h41F; img12[2] = 12'h500;
      img12[3] = 12'h11F; img12[4] = 12'hE00; img12[5] = 12'h11D;
      img12[6] = 12'h400; img12[7] = 12'h61F;
      img12[29] = 12'hF00; img12[30] = 12'hABC;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         rst12 = 1'b0; we12 = 1'b1; addr12 = 5'(i); data12 = img12[i];
      end
      @(posedge clk); #1 we12 = 1'b0; rst12 = 1'b1;
      @(posedge clk); #1 rst12 = 1'b0;
      exp12.push_back(12'hABC);
      @(posedge clk); #1 run12 = 1'b1;
      @(posedge clk); #1 run12 = 1'b0;
      n = 0;
      while (!halted12 && n < 200) begin
         @(posedge clk); #1 n++;
      end
      check("t4_halted", 32'(halted12), 1);
      check("t4_cycles", n, 35);
      check("t4_pc_wrapped", 32'(pc12), 1);
      check("t4_outs_left", exp12.size(), 0);

      // Test 5: a write during RUN is ignored; reset at ADD T3 abandons it.
      img_test1();
      load8();
      reset8();
      @(posedge clk); #1 run8 = 1'b1;
      @(posedge clk); #1;
      run8 = 1'b0; we8 = 1'b1; addr8 = 4'd14; data8 = 8'h00;
      @(posedge clk); #1 we8 = 1'b0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (dut8.state_q == 3'd3 && dut8.ir_q[7:4] == 4'h2) found = 1;
         else begin @(posedge clk); #1; end
      end
      check("t5_add_t3_seen", 32'(found), 1);
      rst8 = 1'b1;
      @(posedge clk); #1 rst8 = 1'b0;
      check("t5_halted", 32'(halted8), 1);
      check("t5_pc", 32'(pc8), 0);
      check("t5_a", 32'(dut8.a_q), 0);
      check("t5_b", 32'(dut8.b_q), 0);
      check("t5_outs_left", exp8.size(), 0);
      exp8.push_back(8'd42);
      go8(0, 100, n);
      check("t5_rerun_cycles", n, 15);
      check("t5_rerun_pc", 32'(pc8), 4);
      check("t5_rerun_outs_left", exp8.size(), 0);

      // Test 6: LDI 9 is written in the same cycle as run; opcode A is a
      // 3-clock NOP, so the run is 4 x 3 clocks and OUT shows 9.
      img8 = '{default: 8'h00};
      img8[1] = 8'hA0; img8[2] = 8'hE0; img8[3] = 8'hF0;
      load8();
      reset8();
      exp8.push_back(8'h09);
      go8(1, 100, n);
      check("t6_cycles", n, 12);
      check("t6_a", 32'(dut8.a_q), 9);
      check("t6_outs_left", exp8.size(), 0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
